// File: rtl/bram_dump_reader_if.sv
// Connection bundle for bram_dump_reader: control, bram32 debug read port and byte stream.
// The master modport is the reader itself; the slave modport is the surrounding system.
interface bram_dump_reader_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 9
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [CNT_WIDTH-1:0]  word_count;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, base_addr, word_count, mem_data, tx_ready,
    output mem_addr, tx_data, tx_valid, busy, done
  );

  modport slave (
    output start, base_addr, word_count, mem_data, tx_ready,
    input  mem_addr, tx_data, tx_valid, busy, done
  );
endinterface

// File: rtl/bram_dump_reader.sv
// Drains a word range from bram32's debug read port and streams it out as bytes,
// least-significant byte first, over a valid/ready handshake.
module bram_dump_reader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 9
) (
  input logic              clk,
  input logic              rst,
  bram_dump_reader_if.master bus
);

  localparam int unsigned BYTES     = DATA_WIDTH / 8;
  localparam int unsigned BIDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned LAST_BYTE = BYTES - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [CNT_WIDTH-1:0]  remaining_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [BIDX_W-1:0]     byte_idx_q;
  logic [7:0]            tx_data_q;
  logic                  tx_valid_q;
  logic                  busy_q;
  logic                  done_q;

  logic [DATA_WIDTH-1:0] shreg_d;
  logic [ADDR_WIDTH-1:0] start_addr_d;
  logic [ADDR_WIDTH-1:0] next_addr_d;
  logic                  accept_d;
  logic                  last_byte_d;
  logic                  unused_base_lsbs;

  // Word-aligned start address; the two byte-offset bits are dropped.
  assign start_addr_d     = {bus.base_addr[ADDR_WIDTH-1:2], 2'b00};
  assign unused_base_lsbs = &{1'b0, bus.base_addr[1:0]};
  assign next_addr_d      = ADDR_WIDTH'(mem_addr_q + ADDR_WIDTH'(4));
  assign shreg_d          = shreg_q >> 8;
  assign accept_d         = tx_valid_q && bus.tx_ready;
  assign last_byte_d      = (byte_idx_q == BIDX_W'(LAST_BYTE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= '0;
      remaining_q <= '0;
      shreg_q     <= '0;
      byte_idx_q  <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.word_count != '0) begin
              mem_addr_q  <= start_addr_d;
              remaining_q <= bus.word_count;
              busy_q      <= 1'b1;
              state_q     <= S_FETCH;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end

        // bram32 samples mem_addr on this edge; data is valid in WAIT.
        S_FETCH: state_q <= S_WAIT;

        S_WAIT: begin
          shreg_q    <= bus.mem_data;
          byte_idx_q <= '0;
          tx_data_q  <= bus.mem_data[7:0];
          tx_valid_q <= 1'b1;
          state_q    <= S_SEND;
        end

        // Without acceptance every stream register holds its value.
        S_SEND: begin
          if (accept_d) begin
            if (!last_byte_d) begin
              shreg_q    <= shreg_d;
              tx_data_q  <= shreg_d[7:0];
              byte_idx_q <= BIDX_W'(byte_idx_q + BIDX_W'(1));
            end else begin
              tx_valid_q  <= 1'b0;
              remaining_q <= CNT_WIDTH'(remaining_q - CNT_WIDTH'(1));
              if (remaining_q == CNT_WIDTH'(1)) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                mem_addr_q <= next_addr_d;
                state_q    <= S_FETCH;
              end
            end
          end
        end

        // done_q was raised on entry; start is deliberately not sampled here.
        S_DONE: state_q <= S_IDLE;

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_addr = mem_addr_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_bram_dump_reader.sv
// Directed bench for bram_dump_reader with a one-cycle-latency BRAM model and byte sink.
module tb_bram_dump_reader;

  logic clk;
  logic rst;

  bram_dump_reader_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .CNT_WIDTH(9)) bus ();

  bram_dump_reader #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .CNT_WIDTH(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:255];
  logic [7:0]  exp_b [0:7];
  logic [9:0]  exp_a [0:1];
  logic [7:0]  got_b [0:15];
  int          n_checks;
  int          n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // bram32 debug port: data valid one clk after the address is presented.
  always @(posedge clk) bus.mem_data <= mem[bus.mem_addr[9:2]];

  task automatic set_exp(input logic [31:0] w0, input logic [31:0] w1,
                         input logic [9:0] a0, input logic [9:0] a1);
    for (int k = 0; k < 4; k++) begin
      exp_b[k]     = w0[8*k +: 8];
      exp_b[4 + k] = w1[8*k +: 8];
    end
    exp_a[0] = a0;
    exp_a[1] = a1;
  endtask

  // Runs one dump from a posedge+1 time point and checks stream, addresses, busy and done.
  task automatic run_dump(input logic [9:0] base, input logic [8:0] cnt, input int n_exp,
                          input int n_words, input int stall_mode, input int exp_busy,
                          input int inject_cyc, input string name);
    int         nb, nw, busy_cyc, done_cnt, tail;
    logic       prev_valid, prev_ready, finished;
    logic [7:0] prev_data;
    nb = 0; nw = 0; busy_cyc = 0; done_cnt = 0; tail = 0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_data = 8'h00; finished = 1'b0;
    bus.base_addr  = base;
    bus.word_count = cnt;
    bus.start      = 1'b1;
    bus.tx_ready   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int cyc = 0; cyc < 400 && tail < 3; cyc++) begin
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.done === 1'b1) done_cnt++;
      if (finished) tail++;
      if (bus.done === 1'b1) finished = 1'b1;
      if (bus.tx_valid === 1'b1 && !prev_valid) begin
        n_checks++;
        if (nw >= n_words) begin
          n_fail++;
          $display("FAIL %s extra_word: word %0d started, only %0d expected", name, nw, n_words);
        end else if (bus.mem_addr !== exp_a[nw]) begin
          n_fail++;
          $display("FAIL %s mem_addr[%0d]: got %h expected %h", name, nw, bus.mem_addr, exp_a[nw]);
        end
        nw++;
      end
      if (prev_valid && !prev_ready) begin
        n_checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_data) begin
          n_fail++;
          $display("FAIL %s stall_hold: got valid=%b data=%h expected valid=1 data=%h",
                   name, bus.tx_valid, bus.tx_data, prev_data);
        end
      end
      bus.tx_ready = (stall_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (bus.tx_valid === 1'b1 && bus.tx_ready) begin
        if (nb < 16) got_b[nb] = bus.tx_data;
        nb++;
      end
      if (cyc == inject_cyc) begin
        bus.start      = 1'b1;
        bus.base_addr  = 10'h100;
        bus.word_count = 9'd5;
      end else begin
        bus.start = 1'b0;
      end
      prev_valid = (bus.tx_valid === 1'b1);
      prev_ready = bus.tx_ready;
      prev_data  = bus.tx_data;
      @(posedge clk); #1;
    end
    bus.start    = 1'b0;
    bus.tx_ready = 1'b0;
    n_checks++;
    if (!finished) begin
      n_fail++;
      $display("FAIL %s timeout: done not seen within 400 cycles", name);
    end
    n_checks++;
    if (nb != n_exp) begin
      n_fail++;
      $display("FAIL %s byte_count: got %0d expected %0d", name, nb, n_exp);
    end
    for (int i = 0; i < n_exp && i < nb; i++) begin
      n_checks++;
      if (got_b[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL %s byte[%0d]: got %h expected %h", name, i, got_b[i], exp_b[i]);
      end
    end
    n_checks++;
    if (nw != n_words) begin
      n_fail++;
      $display("FAIL %s word_count: got %0d expected %0d", name, nw, n_words);
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
    end
    if (exp_busy >= 0) begin
      n_checks++;
      if (busy_cyc != exp_busy) begin
        n_fail++;
        $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cyc, exp_busy);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.mem_addr !== 10'h000) begin
      n_fail++; $display("FAIL reset mem_addr: got %h expected 000", bus.mem_addr);
    end
    n_checks++;
    if (bus.tx_data !== 8'h00) begin
      n_fail++; $display("FAIL reset tx_data: got %h expected 00", bus.tx_data);
    end
    n_checks++;
    if (bus.tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset tx_valid: got %b expected 0", bus.tx_valid);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset busy: got %b expected 0", bus.busy);
    end
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL reset done: got %b expected 0", bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    set_exp(32'h0000_0003, 32'h0000_0001, 10'h000, 10'h004);
    run_dump(10'h000, 9'd2, 8, 2, 0, 12, -1, "basic");
  endtask

  task automatic test_backpressure;
    set_exp(32'h0000_0003, 32'h0000_0001, 10'h000, 10'h004);
    run_dump(10'h000, 9'd2, 8, 2, 1, -1, -1, "backpressure");
  endtask

  task automatic test_zero_count;
    run_dump(10'h020, 9'd0, 0, 0, 0, 0, -1, "zero_count");
  endtask

  task automatic test_wrap;
    set_exp(32'hDEAD_BEEF, 32'h0000_0003, 10'h3FC, 10'h000);
    run_dump(10'h3FE, 9'd2, 8, 2, 0, 12, -1, "wrap");
  endtask

  task automatic test_start_while_busy;
    set_exp(32'h0000_0003, 32'h0000_0001, 10'h000, 10'h004);
    run_dump(10'h000, 9'd2, 8, 2, 0, 12, 5, "start_while_busy");
  endtask

  task automatic test_reset_mid;
    logic found;
    int   done_seen;
    found = 1'b0;
    done_seen = 0;
    bus.base_addr  = 10'h000;
    bus.word_count = 9'd2;
    bus.start      = 1'b1;
    bus.tx_ready   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (bus.tx_valid === 1'b1 && bus.mem_addr === 10'h004) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL reset_mid reach_second_word: got none expected SEND of word 1");
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0 || bus.mem_addr !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_mid async_clear: got valid=%b busy=%b mem_addr=%h expected 0 0 000",
               bus.tx_valid, bus.busy, bus.mem_addr);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) done_seen++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) done_seen++;
    end
    n_checks++;
    if (done_seen != 0) begin
      n_fail++; $display("FAIL reset_mid no_done: got %0d pulses expected 0", done_seen);
    end
    set_exp(32'h0000_0003, 32'h0000_0000, 10'h000, 10'h000);
    run_dump(10'h000, 9'd1, 4, 1, 0, 6, -1, "after_reset");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.word_count = '0;
    bus.tx_ready   = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]   = 32'h0000_0003;
    mem[1]   = 32'h0000_0001;
    mem[255] = 32'hDEAD_BEEF;

    test_reset;
    test_basic;
    test_backpressure;
    test_zero_count;
    test_wrap;
    test_start_while_busy;
    test_reset_mid;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
